// File: rtl/peak_bin_finder.sv
// rtl/peak_bin_finder.sv - per-frame windowed peak power search over an FFT bin stream
module peak_bin_finder #(
  parameter int PWR_W   = 47,
  parameter int NFFT    = 1024,
  parameter int BIN_W   = $clog2(NFFT),
  parameter int MIN_BIN = 0,
  parameter int MAX_BIN = 1023
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [PWR_W-1:0] power_in,
  input  logic             power_valid,
  input  logic             power_last,
  input  logic [PWR_W-1:0] threshold,
  input  logic             clear,
  output logic [PWR_W-1:0] peak_power,
  output logic [BIN_W-1:0] peak_bin,
  output logic             peak_detect,
  output logic             frame_err,
  output logic             peak_valid
);

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_ACCUM  = 1'b1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NFFT - 1);

  // Window membership as a lookup table keeps the compare free of constant-range edge cases.
  function automatic logic [NFFT-1:0] win_mask();
    logic [NFFT-1:0] m;
    for (int i = 0; i < NFFT; i++) m[i] = (i >= MIN_BIN) && (i <= MAX_BIN);
    return m;
  endfunction

  localparam logic [NFFT-1:0] WIN = win_mask();

  logic [0:0]       state;
  logic [BIN_W-1:0] bin_cnt;
  logic [BIN_W-1:0] run_bin;
  logic [PWR_W-1:0] run_max;
  logic             sat;

  logic [PWR_W-1:0] cur_max;
  logic [BIN_W-1:0] cur_bin;
  logic             take;
  logic [PWR_W-1:0] nxt_max;
  logic [BIN_W-1:0] nxt_bin;

  always_comb begin
    cur_max = (state == S_ACCUM) ? run_max : '0;
    cur_bin = (state == S_ACCUM) ? run_bin : '0;
    take    = power_valid && WIN[bin_cnt] && (power_in > cur_max);
    nxt_max = take ? power_in : cur_max;
    nxt_bin = take ? bin_cnt : cur_bin;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= S_IDLE;
      bin_cnt     <= '0;
      run_bin     <= '0;
      run_max     <= '0;
      sat         <= 1'b0;
      peak_power  <= '0;
      peak_bin    <= '0;
      peak_detect <= 1'b0;
      frame_err   <= 1'b0;
      peak_valid  <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      bin_cnt    <= '0;
      run_bin    <= '0;
      run_max    <= '0;
      sat        <= 1'b0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= power_valid && power_last;
      if (power_valid) begin
        if (power_last) begin
          peak_power  <= nxt_max;
          peak_bin    <= nxt_bin;
          peak_detect <= nxt_max > threshold;
          frame_err   <= (bin_cnt != LAST_BIN) || sat;
          state       <= S_IDLE;
          bin_cnt     <= '0;
          run_bin     <= '0;
          run_max     <= '0;
          sat         <= 1'b0;
        end else begin
          state   <= S_ACCUM;
          run_max <= nxt_max;
          run_bin <= nxt_bin;
          // A non-last beat on the final bin means the frame overruns NFFT.
          if (bin_cnt == LAST_BIN) sat <= 1'b1;
          else                     bin_cnt <= bin_cnt + 1'b1;
        end
      end
    end
  end

endmodule
